// File: rtl/scc_mem_port_arbiter.sv
// scc_mem_port_arbiter
// Shares one single-port unified memory between the SCC fetch requester and
// the load/store requester. Each access runs a fixed-latency memory cycle and
// returns read data with a one-cycle valid pulse. Data wins ties, a saturating
// starvation counter forces fetch progress, and halt parks the block in a
// terminal HALTED state.

module scc_mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          halt,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          halted
);

    // lat_cnt counts down from MEM_LAT-1; starve_cnt counts up to STARVE_MAX.
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
    localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    // All architectural state in one record, so reset and hold are uniform.
    typedef struct packed {
        state_t          state;
        owner_t          owner;
        logic [LW-1:0]   lat_cnt;
        logic [SW-1:0]   starve_cnt;
        logic            if_gnt;
        logic            if_rvalid;
        logic [DW-1:0]   if_rdata;
        logic            d_gnt;
        logic            d_rvalid;
        logic [DW-1:0]   d_rdata;
        logic            mem_en;
        logic            mem_we;
        logic [AW-1:0]   mem_addr;
        logic [DW-1:0]   mem_wdata;
    } regs_t;

    regs_t r;
    regs_t r_nxt;
    logic  grant_fetch;
    logic  grant_data;

    // Next-state and output decode: arbitration in IDLE, countdown in ACCESS.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        r_nxt       = r;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;

        // Pulses clear on every edge, including edges with clk_en=0.
        r_nxt.if_gnt    = 1'b0;
        r_nxt.d_gnt     = 1'b0;
        r_nxt.if_rvalid = 1'b0;
        r_nxt.d_rvalid  = 1'b0;

        if (clk_en) begin
            unique case (r.state)
                ST_IDLE: begin
                    if (halt) begin
                        r_nxt.state = ST_HALTED;
                    end else if (d_req && if_req && (r.starve_cnt == SMAX)) begin
                        grant_fetch = 1'b1;
                    end else if (d_req) begin
                        grant_data = 1'b1;
                        if (if_req) begin
                            r_nxt.starve_cnt = (r.starve_cnt == SMAX) ? SMAX
                                             : r.starve_cnt + SW'(1);
                        end else begin
                            r_nxt.starve_cnt = '0;
                        end
                    end else if (if_req) begin
                        grant_fetch = 1'b1;
                    end

                    if (grant_fetch) begin
                        r_nxt.owner      = OWN_FETCH;
                        r_nxt.mem_addr   = if_addr;
                        r_nxt.mem_we     = 1'b0;
                        r_nxt.if_gnt     = 1'b1;
                        r_nxt.starve_cnt = '0;
                    end
                    if (grant_data) begin
                        r_nxt.owner     = OWN_DATA;
                        r_nxt.mem_addr  = d_addr;
                        r_nxt.mem_we    = d_we;
                        r_nxt.mem_wdata = d_wdata;
                        r_nxt.d_gnt     = 1'b1;
                    end
                    if (grant_fetch || grant_data) begin
                        r_nxt.mem_en  = 1'b1;
                        r_nxt.lat_cnt = LAT_INIT;
                        r_nxt.state   = ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (r.lat_cnt != '0) begin
                        r_nxt.lat_cnt = r.lat_cnt - LW'(1);
                    end else begin
                        // Last access cycle: mem_rdata is valid now.
                        if (r.owner == OWN_FETCH) begin
                            r_nxt.if_rdata  = mem_rdata;
                            r_nxt.if_rvalid = 1'b1;
                        end else begin
                            r_nxt.d_rdata  = r.mem_we ? '0 : mem_rdata;
                            r_nxt.d_rvalid = 1'b1;
                        end
                        r_nxt.mem_en = 1'b0;
                        r_nxt.mem_we = 1'b0;
                        r_nxt.owner  = OWN_NONE;
                        r_nxt.state  = halt ? ST_HALTED : ST_IDLE;
                    end
                end

                ST_HALTED: begin
                    r_nxt.mem_en = 1'b0;
                    r_nxt.mem_we = 1'b0;
                end

                default: begin
                    r_nxt.state = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            r <= '0;
        end else begin
            r <= r_nxt;
        end
    end

    assign if_gnt    = r.if_gnt;
    assign if_rvalid = r.if_rvalid;
    assign if_rdata  = r.if_rdata;
    assign d_gnt     = r.d_gnt;
    assign d_rvalid  = r.d_rvalid;
    assign d_rdata   = r.d_rdata;
    assign mem_en    = r.mem_en;
    assign mem_we    = r.mem_we;
    assign mem_addr  = r.mem_addr;
    assign mem_wdata = r.mem_wdata;
    assign busy      = (r.state == ST_ACCESS);
    assign halted    = (r.state == ST_HALTED);

endmodule
